// File: rtl/enc_dec_seq_ctrl.sv
// enc_dec_seq_ctrl
//   Sequencer for the encoder/decoder datapath. A start strobe latches the
//   operating mode and codeword width, then the block handshakes with the
//   encoder and/or decoder engines, guarding each wait with a timeout.
//   Completion is reported as one-cycle op_done/op_err pulses plus sticky
//   status bits.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, mode, cw_sel operation request, mode (00 enc, 01 dec, 10 full
//                       channel) and codeword width select (00/01/10 = 8/16/32)
//   enc_go / enc_done   encoder request level / completion strobe
//   dec_go / dec_done   decoder request level / completion strobe
//   dec_src, noise_en   decoder input from encoder output, noise XOR enable
//   cw_len              active codeword width, 0 when idle
//   busy                operation in progress
//   op_done, op_err     one-cycle completion / abort pulses
//   err_sticky, overrun last operation aborted / start seen while busy
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// ENC   | encoder running, enc_go high, timeout armed
// DEC   | decoder running, dec_go high, timeout armed
// DONE  | one-cycle op_done pulse
// ERR   | one-cycle op_err pulse, err_sticky set on exit

module enc_dec_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] cw_sel,
    output logic       enc_go,
    input  logic       enc_done,
    output logic       dec_go,
    input  logic       dec_done,
    output logic       dec_src,
    output logic       noise_en,
    output logic [5:0] cw_len,
    output logic       busy,
    output logic       op_done,
    output logic       op_err,
    output logic       err_sticky,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ENC  = 3'd1,
        S_DEC  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0]       MODE_ENC  = 2'b00;
    localparam logic [1:0]       MODE_DEC  = 2'b01;
    localparam logic [1:0]       MODE_FULL = 2'b10;
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       cw_sel_q, cw_sel_d;
    logic             err_sticky_q, err_sticky_d;
    logic             overrun_q, overrun_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= 2'b00;
            cw_sel_q     <= 2'b00;
            err_sticky_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            cw_sel_q     <= cw_sel_d;
            err_sticky_q <= err_sticky_d;
            overrun_q    <= overrun_d;
        end
    end

    // The timeout counter counts down from TIMEOUT-1; reaching zero without
    // a done strobe aborts. A done on that same final cycle still completes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        cw_sel_d     = cw_sel_q;
        err_sticky_d = err_sticky_q;
        overrun_d    = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    cw_sel_d     = cw_sel;
                    err_sticky_d = 1'b0;
                    overrun_d    = 1'b0;
                    cnt_d        = TO_LOAD;
                    if (mode == 2'b11 || cw_sel == 2'b11) begin
                        state_d = S_ERR;
                        cnt_d   = '0;
                    end else if (mode == MODE_DEC) begin
                        state_d = S_DEC;
                    end else begin
                        state_d = S_ENC;
                    end
                end
            end
            S_ENC: begin
                if (enc_done) begin
                    if (mode_q == MODE_FULL) begin
                        state_d = S_DEC;
                        cnt_d   = TO_LOAD;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DEC: begin
                if (dec_done) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_sticky_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (start && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end
    end

    // All outputs decode from registered state, so reset clears them at once.
    always_comb begin
        enc_go   = (state_q == S_ENC);
        dec_go   = (state_q == S_DEC);
        dec_src  = (state_q == S_DEC) && (mode_q == MODE_FULL);
        noise_en = (state_q == S_DEC) && (mode_q == MODE_FULL);
        busy     = (state_q != S_IDLE);
        op_done  = (state_q == S_DONE);
        op_err   = (state_q == S_ERR);
        cw_len   = 6'd0;
        if (state_q != S_IDLE) begin
            case (cw_sel_q)
                2'b00:   cw_len = 6'd8;
                2'b01:   cw_len = 6'd16;
                2'b10:   cw_len = 6'd32;
                default: cw_len = 6'd0;
            endcase
        end
    end

    assign err_sticky = err_sticky_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_enc_dec_seq_ctrl.sv
module tb_enc_dec_seq_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] cw_sel = 2'b00;
    logic       enc_done = 1'b0;
    logic       dec_done = 1'b0;
    logic       enc_go, dec_go, dec_src, noise_en, busy, op_done, op_err;
    logic       err_sticky, overrun;
    logic [5:0] cw_len;

    int checks = 0;
    int failures = 0;

    enc_dec_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cw_sel(cw_sel),
        .enc_go(enc_go), .enc_done(enc_done), .dec_go(dec_go), .dec_done(dec_done),
        .dec_src(dec_src), .noise_en(noise_en), .cw_len(cw_len), .busy(busy),
        .op_done(op_done), .op_err(op_err), .err_sticky(err_sticky), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Observation vector: {enc_go, dec_go, dec_src, noise_en, busy, op_done,
    //                      op_err, err_sticky, overrun, cw_len[5:0]}
    typedef logic [14:0] obs_t;
    localparam obs_t OVR_BIT = 15'h0040;
    localparam obs_t IDLE_OBS = 15'h0000;

    function automatic obs_t mk(bit eg, bit dg, bit ds, bit ne, bit bz, bit od,
                                bit oe, bit es, bit ov, logic [5:0] cl);
        return {eg, dg, ds, ne, bz, od, oe, es, ov, cl};
    endfunction

    function automatic obs_t sample();
        return {enc_go, dec_go, dec_src, noise_en, busy, op_done, op_err,
                err_sticky, overrun, cw_len};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t exp_v);
        obs_t got;
        got = sample();
        checks++;
        assert (got === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
        end
    endtask

    // Reference model: an operation is a sequence of phases. A wait phase
    // lasts lat+1 cycles when its done strobe comes lat cycles after go rises
    // (lat < TIMEOUT), otherwise TIMEOUT cycles followed by an abort.
    task automatic run_op(input logic [1:0] m, input logic [1:0] c,
                          input int le, input int ld, input int ovr_sel,
                          input string tag);
        obs_t exp_q[$];
        bit   ed_q[$];
        bit   dd_q[$];
        bit   legal;
        bit   ok;
        bit   full;
        int   n;
        int   ovr_at;
        logic [5:0] len;

        legal = (m != 2'b11) && (c != 2'b11);
        full  = (m == 2'b10);
        len   = (c == 2'b00) ? 6'd8 : (c == 2'b01) ? 6'd16 : (c == 2'b10) ? 6'd32 : 6'd0;
        ok    = legal;

        if (legal && m != 2'b01) begin
            n = (le < TIMEOUT) ? le + 1 : TIMEOUT;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, len));
                ed_q.push_back(j == le);
                dd_q.push_back(1'b0);
            end
            ok = (le < TIMEOUT);
        end
        if (legal && (m == 2'b01 || (full && ok))) begin
            n = (ld < TIMEOUT) ? ld + 1 : TIMEOUT;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(mk(0, 1, full, full, 1, 0, 0, 0, 0, len));
                ed_q.push_back(1'b0);
                dd_q.push_back(j == ld);
            end
            ok = (ld < TIMEOUT);
        end
        exp_q.push_back(mk(0, 0, 0, 0, 1, ok, !ok, 0, 0, len));
        ed_q.push_back(1'b0);
        dd_q.push_back(1'b0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, !ok, 0, 6'd0));
        ed_q.push_back(1'b0);
        dd_q.push_back(1'b0);

        // busy cycles are indices 0 .. size-2
        ovr_at = (ovr_sel >= 0) ? ovr_sel % (exp_q.size() - 1) : -1;

        start  = 1'b1;
        mode   = m;
        cw_sel = c;
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            start    = (i == ovr_at);
            enc_done = ed_q[i];
            dec_done = dd_q[i];
            mode     = 2'($urandom);
            cw_sel   = 2'($urandom);
            check(tag, exp_q[i] | ((ovr_at >= 0 && i > ovr_at) ? OVR_BIT : 15'h0));
            tick();
        end
        start    = 1'b0;
        enc_done = 1'b0;
        dec_done = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_state", IDLE_OBS);
        rst = 1'b0;
        tick();
        check("idle_after_reset", IDLE_OBS);

        // done strobes while idle have no effect
        enc_done = 1'b1;
        dec_done = 1'b1;
        tick();
        enc_done = 1'b0;
        dec_done = 1'b0;
        check("idle_stray_done", IDLE_OBS);

        run_op(2'b00, 2'b00, 3, 99, -1, "enc_w8");
        run_op(2'b10, 2'b10, 2, 4, -1, "full_w32");
        run_op(2'b11, 2'b00, 0, 0, -1, "illegal_mode");
        run_op(2'b01, 2'b01, 0, 1, -1, "dec_clears_sticky");
        run_op(2'b00, 2'b11, 0, 0, -1, "illegal_width");
        run_op(2'b01, 2'b00, 0, 99, -1, "dec_timeout");
        run_op(2'b00, 2'b01, 5, 0, 2, "enc_overrun");
        run_op(2'b01, 2'b10, 0, TIMEOUT - 1, -1, "dec_done_at_limit");
        run_op(2'b10, 2'b00, TIMEOUT, 0, -1, "full_enc_timeout");
        run_op(2'b10, 2'b01, TIMEOUT - 1, TIMEOUT - 1, 7, "full_both_limit");

        for (int k = 0; k < 24; k++) begin
            run_op(2'($urandom), 2'($urandom),
                   int'($urandom_range(0, TIMEOUT + 2)),
                   int'($urandom_range(0, TIMEOUT + 2)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1,
                   "random_op");
        end

        // reset in the middle of a decode
        start  = 1'b1;
        mode   = 2'b01;
        cw_sel = 2'b10;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("dec_running", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 6'd32));
        rst = 1'b1;
        #1;
        check("async_reset_mid_dec", IDLE_OBS);
        tick();
        check("held_reset", IDLE_OBS);
        rst = 1'b0;
        tick();
        check("after_reset_no_pulse", IDLE_OBS);
        run_op(2'b00, 2'b10, 1, 0, -1, "post_reset_enc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
